// File: rtl/detector_arbiter.sv
// Round-robin arbiter that lends one 2-bit sequence detector to N_REQ serial lanes,
// one frame of FRAME_LEN bits at a time, and reports the hit count per frame.
module detector_arbiter #(
  parameter int N_REQ     = 4,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         bit_in,
  output logic [N_REQ-1:0]         grant,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(N_REQ)-1:0] done_id,
  output logic [CNT_W-1:0]         hit_count
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int BC_W = $clog2(FRAME_LEN + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]      state;
  logic [ID_W-1:0] sel;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] winner;
  logic [1:0]      q;
  logic [1:0]      q_next;
  logic            w;
  logic            hit;
  logic [BC_W-1:0] bit_cnt;
  logic            last_bit;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] acc_next;

  // Walk offsets from farthest to nearest so the first requester after ptr wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    winner = ptr;
    for (int i = N_REQ; i >= 1; i--) begin
      if (req[(int'(ptr) + i) % N_REQ]) winner = ID_W'((int'(ptr) + i) % N_REQ);
    end
  end

  assign w        = bit_in[sel];
  assign q_next   = {(q[1] & ~q[0]) | (w & q[0]),
                     (w & ~q[0]) | (q[1] & ~q[0]) | (w & q[1])};
  assign hit      = &q_next;
  assign acc_next = (hit && (acc != '1)) ? acc + 1'b1 : acc;
  assign last_bit = (bit_cnt == BC_W'(FRAME_LEN - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      sel       <= '0;
      ptr       <= ID_W'(N_REQ - 1);
      q         <= 2'b00;
      bit_cnt   <= '0;
      acc       <= '0;
      done_id   <= '0;
      hit_count <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
      case (state)
        S_IDLE: begin
          if (|req) begin
            sel   <= winner;
            state <= S_GRANT;
          end
        end
        S_GRANT: begin
          q       <= 2'b00;
          bit_cnt <= '0;
          acc     <= '0;
          state   <= S_SHIFT;
        end
        S_SHIFT: begin
          q       <= q_next;
          bit_cnt <= bit_cnt + 1'b1;
          acc     <= acc_next;
          // Results are captured on the way into DONE so they are valid during the pulse.
          if (last_bit) begin
            hit_count <= acc_next;
            done_id   <= sel;
            state     <= S_DONE;
          end
        end
        default: begin
          ptr   <= sel;
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    grant = '0;
    if (state == S_GRANT || state == S_SHIFT) grant[sel] = 1'b1;
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_detector_arbiter.sv
// Directed bench for detector_arbiter: single frames, round-robin rotation,
// detector clearing, req drop mid-frame and asynchronous reset mid-frame.
module tb_detector_arbiter;

  logic       clock;
  logic       resetn;
  logic [3:0] req;
  logic [3:0] bit_in;
  logic [3:0] grant;
  logic       busy;
  logic       done;
  logic [1:0] done_id;
  logic [3:0] hit_count;

  int checks = 0;
  int errors = 0;

  detector_arbiter #(.N_REQ(4), .FRAME_LEN(8), .CNT_W(4)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .req       (req),
    .bit_in    (bit_in),
    .grant     (grant),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .hit_count (hit_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One full frame starting from IDLE; other lanes carry inverted bits to prove
  // that only the granted lane is sampled.
  task automatic frame(input string tag, input logic [3:0] req_val, input int exp_id,
                       input logic [7:0] bits, input logic [3:0] exp_hits,
                       input int drop_after, input logic [3:0] drop_req,
                       output time t_grant);
    int         waited;
    int         gcount;
    logic [3:0] exp_g;
    waited  = 0;
    gcount  = 0;
    exp_g   = 4'b0001 << exp_id;
    req     = req_val;
    do begin
      step();
      waited++;
    end while (grant === 4'b0000 && waited < 20);
    t_grant = $time;
    check({tag, "_grant"}, {28'b0, grant}, {28'b0, exp_g});
    check({tag, "_grant_busy"}, {31'b0, busy}, 32'd1);
    if (grant === exp_g) gcount++;
    step();
    for (int k = 0; k < 8; k++) begin
      if (grant === exp_g) gcount++;
      check({tag, "_shift"}, {26'b0, done, busy, grant}, {26'b0, 1'b0, 1'b1, exp_g});
      bit_in = bits[k] ? exp_g : ~exp_g;
      if (k == drop_after) req = drop_req;
      step();
    end
    check({tag, "_done"}, {31'b0, done}, 32'd1);
    check({tag, "_done_id"}, {30'b0, done_id}, exp_id);
    check({tag, "_hits"}, {28'b0, hit_count}, {28'b0, exp_hits});
    check({tag, "_done_grant"}, {27'b0, busy, grant}, {27'b0, 1'b1, 4'b0000});
    check({tag, "_grant_cycles"}, gcount, 32'd9);
    step();
    check({tag, "_idle"}, {26'b0, done, busy, grant}, 32'd0);
    check({tag, "_hits_held"}, {28'b0, hit_count}, {28'b0, exp_hits});
  endtask

  initial begin
    time        t_now;
    time        t_prev;
    logic [1:0] rr_id   [4];
    logic [7:0] rr_bits [4];
    logic [3:0] rr_hits [4];

    rr_id   = '{2'd0, 2'd1, 2'd2, 2'd3};
    rr_bits = '{8'h33, 8'hFF, 8'h00, 8'h06};
    rr_hits = '{4'd2, 4'd6, 4'd0, 4'd1};

    resetn = 1'b0;
    req    = 4'b0000;
    bit_in = 4'b0000;
    step();
    step();
    check("reset_outputs", {23'b0, grant, busy, done, done_id, hit_count}, 32'd0);
    resetn = 1'b1;
    step();
    check("idle_no_req", {26'b0, done, busy, grant}, 32'd0);

    // All ones on lane 0: states 01,10,11,11,11,11,11,11 -> 6 hits.
    frame("ones_r0", 4'b0001, 0, 8'hFF, 4'd6, -1, 4'b0000, t_now);

    // All zeros right after a frame that ended in 11 -> detector must be cleared.
    frame("zeros_r3", 4'b1000, 3, 8'h00, 4'd0, -1, 4'b0000, t_now);

    // Pointer now at 3: all four requesting rotates 0,1,2,3 every 11 cycles.
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      frame("rr", 4'b1111, int'(rr_id[i]), rr_bits[i], rr_hits[i], -1, 4'b0000, t_now);
      if (i > 0) check("rr_period", 32'(t_now - t_prev), 32'd110);
      t_prev = t_now;
    end

    // Lane 2, bits 1,1,0,0,1,1,0,0: states 01,10,11,00,01,10,11,00 -> 2 hits.
    frame("r2_1100", 4'b0100, 2, 8'h33, 4'd2, -1, 4'b0000, t_now);

    // Lane 1 drops req after bit 2; only bit 7 completes the hit, so all 8 bits count.
    frame("drop_r1", 4'b0010, 1, 8'hE0, 4'd1, 2, 4'b1001, t_now);
    // Pointer at 1 with req 1001 pending: lane 3 is next.
    frame("after_drop", 4'b1001, 3, 8'hFF, 4'd6, -1, 4'b0000, t_now);

    // Reset asserted while bit 4 is on the wire.
    req = 4'b0001;
    step();
    check("rst_frame_grant", {28'b0, grant}, 32'h1);
    step();
    for (int k = 0; k < 4; k++) begin
      bit_in = 4'b0001;
      step();
    end
    bit_in = 4'b0001;
    #3 resetn = 1'b0;
    #1;
    check("rst_async_outputs", {23'b0, grant, busy, done, done_id, hit_count}, 32'd0);
    step();
    check("rst_held_no_done", {30'b0, done, busy}, 32'd0);
    resetn = 1'b1;
    frame("post_reset", 4'b0001, 0, 8'h33, 4'd2, -1, 4'b0000, t_now);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
